// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/sequencing controller: per-cycle RUN/STALL/FLUSH/MEM_WAIT decision,
// saturating stall counter and sticky memory-timeout flag. Optional macro: FORWARDING_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | front end advances; a jump in ID flushes one IF/ID slot
// STALL    | PC and IF/ID hold, bubble into ID/EX (RAW hazard)
// FLUSH    | taken branch: zero IF/ID, bubble ID/EX, PC loads target
// MEM_WAIT | data memory not ready: freeze front end, ID/EX and EX/MEM
module pipe_hazard_ctrl #(
    parameter int STALL_CNT_W = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_uses_rt,
    input  logic                   jump_in_id,
    input  logic [4:0]             id_ex_rd,
    input  logic                   id_ex_reg_write,
    input  logic                   id_ex_mem_read,
    input  logic [4:0]             ex_mem_rd,
    input  logic                   ex_mem_reg_write,
    input  logic                   branch_taken,
    input  logic                   dmem_req,
    input  logic                   dmem_ready,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   if_id_flush,
    output logic                   id_ex_bubble,
    output logic                   id_ex_hold,
    output logic                   ex_mem_hold,
    output logic [1:0]             state,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic                   mem_timeout
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } mode_e;

    localparam logic [STALL_CNT_W-1:0] STALL_MAX   = '1;
    localparam logic [STALL_CNT_W-1:0] STALL_ONE   = STALL_CNT_W'(1);
    localparam logic [15:0]            TIMEOUT_VAL = 16'(MEM_TIMEOUT);

    mode_e       state_q;
    mode_e       decision;
    logic [15:0] wait_cnt;
    logic [15:0] wait_cnt_inc;
    logic        load_use;
    logic        raw_hazard;

    function automatic logic reg_match(input logic [4:0] r, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic uses_rt);
        return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

    assign load_use = id_ex_mem_read && id_ex_reg_write
                      && reg_match(id_ex_rd, id_rs, id_rt, id_uses_rt);

`ifdef FORWARDING_EN
    logic unused_fwd;
    assign unused_fwd = ^{ex_mem_rd, ex_mem_reg_write};
    assign raw_hazard = load_use;
`else
    // Without bypass paths any in-flight writer of a source register must drain first.
    assign raw_hazard = load_use
                        || (id_ex_reg_write && reg_match(id_ex_rd, id_rs, id_rt, id_uses_rt))
                        || (ex_mem_reg_write && reg_match(ex_mem_rd, id_rs, id_rt, id_uses_rt));
`endif

    always_comb begin
        decision     = RUN;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        id_ex_hold   = 1'b0;
        ex_mem_hold  = 1'b0;
        if (dmem_req && !dmem_ready) begin
            decision    = MEM_WAIT;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_hold  = 1'b1;
            ex_mem_hold = 1'b1;
        end else if (branch_taken) begin
            decision     = FLUSH;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (raw_hazard) begin
            decision     = STALL;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else begin
            if_id_flush  = jump_in_id;
        end
    end

    assign wait_cnt_inc = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RUN;
            stall_cycles <= '0;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
        end else begin
            state_q <= decision;
            if ((decision == STALL || decision == MEM_WAIT) && stall_cycles != STALL_MAX)
                stall_cycles <= stall_cycles + STALL_ONE;
            if (decision == MEM_WAIT) begin
                wait_cnt <= wait_cnt_inc;
                if (wait_cnt_inc == TIMEOUT_VAL)
                    mem_timeout <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random stimulus
// against a behavioural model; small counter/timeout parameters to reach the boundaries.
module tb_pipe_hazard_ctrl;

    localparam int W   = 4;
    localparam int TO  = 4;
    localparam int SMAX = (1 << W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_ex_rd = '0, ex_mem_rd = '0;
    logic id_uses_rt = 1'b0, jump_in_id = 1'b0;
    logic id_ex_reg_write = 1'b0, id_ex_mem_read = 1'b0, ex_mem_reg_write = 1'b0;
    logic branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
    logic pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_hold;
    logic [1:0] state;
    logic [W-1:0] stall_cycles;
    logic mem_timeout;

    int errors = 0;
    int checks = 0;

    pipe_hazard_ctrl #(.STALL_CNT_W(W), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .jump_in_id(jump_in_id),
        .id_ex_rd(id_ex_rd), .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
        .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .id_ex_hold(id_ex_hold), .ex_mem_hold(ex_mem_hold),
        .state(state), .stall_cycles(stall_cycles), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Output vectors {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_hold}
    localparam logic [5:0] OUT_TBL [0:3] = '{6'b110000, 6'b000100, 6'b101100, 6'b000011};

    int m_state = 0, m_stall = 0, m_wait = 0;
    bit m_to = 0;

    function automatic bit hits(input logic [4:0] r);
        return r != 0 && (r == id_rs || (id_uses_rt && r == id_rt));
    endfunction

    function automatic int model_mode();
        bit stall_now;
        stall_now = id_ex_mem_read && id_ex_reg_write && hits(id_ex_rd);
`ifndef FORWARDING_EN
        stall_now = stall_now || (id_ex_reg_write && hits(id_ex_rd))
                              || (ex_mem_reg_write && hits(ex_mem_rd));
`endif
        if (dmem_req && !dmem_ready) return 3;
        if (branch_taken) return 2;
        if (stall_now) return 1;
        return 0;
    endfunction

    function automatic logic [5:0] model_outs();
        int md;
        logic [5:0] v;
        md = model_mode();
        v = OUT_TBL[md];
        if (md == 0 && jump_in_id) v[3] = 1'b1;
        return v;
    endfunction

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            m_state = 0; m_stall = 0; m_wait = 0; m_to = 0;
        end else begin
            int md;
            md = model_mode();
            m_state = md;
            if (md == 1 || md == 3) m_stall = (m_stall < SMAX) ? m_stall + 1 : SMAX;
            m_wait = (md == 3) ? m_wait + 1 : 0;
            if (m_wait >= TO) m_to = 1;
        end
    end

    always @(posedge clk) begin
        chk("decision_outs",
            int'({pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_hold}),
            int'(model_outs()));
        chk("state", int'(state), m_state);
        chk("stall_cycles", int'(stall_cycles), m_stall);
        chk("mem_timeout", int'(mem_timeout), int'(m_to));
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_pt();
        @(negedge clk); #1;
    endtask

    task automatic sample_pt();
        @(posedge clk); #1;
    endtask

    task automatic quiet();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; jump_in_id = 0;
        id_ex_rd = 0; id_ex_reg_write = 0; id_ex_mem_read = 0;
        ex_mem_rd = 0; ex_mem_reg_write = 0;
        branch_taken = 0; dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic load_use_inputs(input logic [4:0] rd);
        quiet();
        id_ex_mem_read = 1; id_ex_reg_write = 1; id_ex_rd = rd; id_rs = 5;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        quiet();
        reset = 0;
        sample_pt();
        chk("rst_state", int'(state), 0);
        chk("rst_stall", int'(stall_cycles), 0);
        chk("rst_pc_write", int'(pc_write), 1);
        chk("rst_if_id_write", int'(if_id_write), 1);
        drive_pt(); reset = 1;

        // load-use stall, exactly one cycle
        drive_pt(); load_use_inputs(5);
        sample_pt();
        chk("lu_pc_write", int'(pc_write), 0);
        chk("lu_if_id_write", int'(if_id_write), 0);
        chk("lu_bubble", int'(id_ex_bubble), 1);
        drive_pt(); quiet();
        sample_pt();
        chk("lu_state", int'(state), 1);
        chk("lu_release", int'(pc_write), 1);
        chk("lu_count", int'(stall_cycles), 1);
        drive_pt(); load_use_inputs(0);
        sample_pt();
        chk("lu_r0_no_stall", int'(pc_write), 1);

        // memory wait with pending branch
        for (int i = 0; i < 3; i++) begin
            drive_pt(); quiet(); dmem_req = 1; branch_taken = 1;
            sample_pt();
            chk("mw_holds", int'({pc_write, if_id_write, id_ex_hold, ex_mem_hold}), 4'b0011);
        end
        drive_pt(); dmem_ready = 1;
        sample_pt();
        chk("mw_ready_state", int'(state), 3);
        chk("mw_ready_flush", int'(if_id_flush), 1);
        chk("mw_ready_bubble", int'(id_ex_bubble), 1);
        chk("mw_count", int'(stall_cycles), 4);

        // timeout after 4 consecutive waits
        for (int k = 1; k <= 5; k++) begin
            drive_pt(); quiet(); dmem_req = 1;
            sample_pt();
            chk("to_rise", int'(mem_timeout), (k >= 5) ? 1 : 0);
        end
        drive_pt(); dmem_ready = 1;
        drive_pt(); quiet();
        sample_pt();
        chk("to_sticky", int'(mem_timeout), 1);
        chk("to_count", int'(stall_cycles), 9);

        // forwarding-dependent RAW
        drive_pt(); quiet();
        id_ex_reg_write = 1; id_ex_rd = 3; id_rt = 3; id_uses_rt = 1;
        sample_pt();
`ifdef FORWARDING_EN
        chk("fwd_no_stall", int'(pc_write), 1);
`else
        chk("nofwd_stall1", int'(pc_write), 0);
        drive_pt(); id_ex_reg_write = 0; ex_mem_reg_write = 1; ex_mem_rd = 3;
        sample_pt();
        chk("nofwd_stall2", int'(pc_write), 0);
        chk("nofwd_count", int'(stall_cycles), 10);
`endif

        // async reset in the middle of a memory wait
        drive_pt(); quiet(); reset = 0;
        drive_pt(); reset = 1;
        for (int i = 0; i < 8; i++) begin
            drive_pt(); quiet(); dmem_req = 1;
        end
        sample_pt();
        chk("pre_rst_state", int'(state), 3);
        chk("pre_rst_count", int'(stall_cycles), 7);
        chk("pre_rst_to", int'(mem_timeout), 1);
        #1 reset = 0;
        #1;
        chk("arst_state", int'(state), 0);
        chk("arst_count", int'(stall_cycles), 0);
        chk("arst_to", int'(mem_timeout), 0);
        quiet();
        #1;
        chk("arst_pc_write", int'(pc_write), 1);
        drive_pt(); reset = 1;

        // saturation of the stall counter
        for (int i = 0; i < 20; i++) begin
            drive_pt(); load_use_inputs(5);
        end
        drive_pt(); quiet();
        sample_pt();
        chk("sat_count", int'(stall_cycles), SMAX);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive_pt();
            reset            = ($urandom_range(0, 199) != 0);
            id_rs            = 5'($urandom_range(0, 3));
            id_rt            = 5'($urandom_range(0, 3));
            id_uses_rt       = 1'($urandom_range(0, 1));
            jump_in_id       = ($urandom_range(0, 3) == 0);
            id_ex_rd         = 5'($urandom_range(0, 3));
            id_ex_reg_write  = 1'($urandom_range(0, 1));
            id_ex_mem_read   = 1'($urandom_range(0, 1));
            ex_mem_rd        = 5'($urandom_range(0, 3));
            ex_mem_reg_write = 1'($urandom_range(0, 1));
            branch_taken     = ($urandom_range(0, 4) == 0);
            dmem_req         = ($urandom_range(0, 2) == 0);
            dmem_ready       = ($urandom_range(0, 3) == 0);
        end
        drive_pt(); quiet(); reset = 1;
        sample_pt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipelined processor. It decides, once per cycle, whether the front end (PC, IF/ID) advances or stalls, and whether ID/EX and later registers latch, take a bubble or hold. It also decides whether wrong-path instructions are flushed. It watches the ID-stage source registers, the ID/EX and EX/MEM destination fields, branch/jump resolution and the data-memory handshake. It also keeps a stall-cycle counter and a memory-timeout flag.

## Interface
Parameters:
- STALL_CNT_W, 16, width of the stall-cycle counter.
- MEM_TIMEOUT, 255, number of consecutive MEM_WAIT cycles that sets mem_timeout; legal range 1..65535.

Ports:
- clk  in  1  processor clock; all state updates on the falling edge, like every pipeline register.
- reset  in  1  asynchronous, active-low reset.
- id_rs, id_rt  in  5 each  source register fields of the instruction in ID.
- id_uses_rt  in  1  rt is a source operand, not a destination.
- jump_in_id  in  1  jump decoded in ID.
- id_ex_rd  in  5  destination in EX. id_ex_reg_write, id_ex_mem_read  in  1 each.
- ex_mem_rd  in  5  destination in MEM. ex_mem_reg_write  in  1.
- branch_taken  in  1  branch resolved taken in EX.
- dmem_req, dmem_ready  in  1 each  data-memory request and ready from the MEM stage.
- pc_write, if_id_write  out  1 each  front-end enables.
- if_id_flush  out  1  zero the IF/ID instruction.
- id_ex_bubble  out  1  force all ID/EX control bits to 0.
- id_ex_hold, ex_mem_hold  out  1 each  freeze the register.
- state  out  2  RUN=0, STALL=1, FLUSH=2, MEM_WAIT=3.
- stall_cycles  out  STALL_CNT_W  saturating count of STALL plus MEM_WAIT cycles.
- mem_timeout  out  1  sticky error flag.

## Operation
Match rules:
- match(r) = r != 0 and (r == id_rs or (id_uses_rt and r == id_rt)).
- Load-use hazard = id_ex_mem_read and id_ex_reg_write and match(id_ex_rd).

Each cycle a combinational decision is taken, in strict priority:
- MEM_WAIT when dmem_req and not dmem_ready. Outputs: pc_write=0, if_id_write=0, id_ex_hold=1, ex_mem_hold=1. Branch, jump and stall are ignored; they persist because EX and ID are frozen.
- FLUSH when branch_taken. Outputs: pc_write=1, if_id_flush=1, id_ex_bubble=1. Any load-use hazard is suppressed because the instruction in ID is wrong-path.
- STALL when a load-use hazard exists. Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1.
- RUN otherwise. Outputs: pc_write=1, if_id_write=1, all others 0. If jump_in_id is also set, if_id_flush=1 (one wrong-path slot; ID/EX already refuses to latch on jump).

Registered behaviour:
- state is the decision latched at the falling edge, so it shows the previous cycle's mode.
- stall_cycles increments when the decision is STALL or MEM_WAIT. It saturates at all-ones.
- wait_cnt (internal, 16 bit) increments while the decision is MEM_WAIT and clears on any other decision.
- mem_timeout sets when wait_cnt reaches MEM_TIMEOUT. It stays set until reset; the pipeline keeps waiting regardless.

## Timing
- Decision outputs are combinational from the inputs. They are valid within the high phase and consumed at the same falling edge, so hazard response has zero-cycle latency.
- A load-use stall lasts exactly 1 cycle: after the bubble, the load has moved to MEM and no longer matches.
- A branch flush lasts 1 cycle and removes 2 wrong-path slots (IF/ID and ID/EX).
- MEM_WAIT lasts as long as dmem_ready stays low. Release happens in the cycle ready is seen high, with no extra cycle.
- Reset (reset=0) forces immediately, regardless of clk:
  - state=RUN, stall_cycles=0, wait_cnt=0, mem_timeout=0.
  - The decision outputs return to RUN values once inputs are quiet.
  - Reset asserted mid-MEM_WAIT or mid-STALL abandons the operation; no partial count is kept.
- Simultaneous events:
  - branch_taken with a load-use hazard gives FLUSH.
  - jump_in_id with a load-use hazard gives STALL; the jump is re-seen next cycle.
  - dmem_req with branch_taken gives MEM_WAIT first, then FLUSH.

## Configuration
- FORWARDING_EN defined: EX/MEM and MEM/WB forwarding exists, so only the load-use hazard stalls.
- FORWARDING_EN undefined: a STALL decision is also taken for:
  - id_ex_reg_write and match(id_ex_rd), or
  - ex_mem_reg_write and match(ex_mem_rd).
- The priority order is unchanged. A dependent instruction can then stall up to 2 cycles (assumes write-before-read in the register file).

## Test plan
- Reset: pulse reset low while in MEM_WAIT with stall_cycles=7 -> immediately state=0, stall_cycles=0, mem_timeout=0; with quiet inputs pc_write=1.
- Load-use: id_ex_mem_read=1, id_ex_reg_write=1, id_ex_rd=5, id_rs=5 -> one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle RUN; stall_cycles=1. Repeat with id_ex_rd=0 -> no stall.
- Memory wait with branch: dmem_req=1, dmem_ready=0 for 3 cycles with branch_taken=1 -> 3 cycles of all holds, stall_cycles=3. On the ready cycle the decision is FLUSH (if_id_flush=1, id_ex_bubble=1), with state=3 during that cycle.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> mem_timeout rises at the 4th MEM_WAIT edge and stays 1 after ready returns, until reset.
- Forwarding: id_ex_reg_write=1, id_ex_mem_read=0, id_ex_rd=3, id_rt=3, id_uses_rt=1 -> no stall with FORWARDING_EN; one STALL cycle without it, then a second STALL from the EX/MEM match.
- Saturation: STALL_CNT_W=4, 20 stall cycles -> stall_cycles holds at 15.
